seg_display_dec: RTL and testbench
==================================

# seg_display_dec

- Display-side decoder for the microwave keypad/timer path.
- Latches four BCD digits (mm:ss) from the timer/encoder side and turns them into multiplexed 7-segment drive.
- Time-multiplexes the four digits at a programmable refresh rate.
- Provides leading-zero blanking, an invalid-code dash, the mm:ss separator dot, and a whole-display blink for "done"/"set" states.

## Interface
- REFRESH_DIV, default 4: clock cycles each digit stays active (>=1).
- BLINK_DIV, default 8: complete 4-digit scans per blink half-period (>=1).
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- load  in  1  when high at a clk edge, digits is captured into the shadow register.
- digits  in  16  four BCD nibbles:
  - [15:12] tens of minutes (digit 3)
  - [11:8] minutes (digit 2)
  - [7:4] tens of seconds (digit 1)
  - [3:0] seconds (digit 0)
- blank_lz  in  1  1 = blank leading zeros.
- blink_en  in  1  1 = blink whole display.
- seg  out  7  active-high segments {g,f,e,d,c,b,a}.
- an  out  4  one-hot active-low digit enables; an[i] drives digit i.
- dp  out  1  active-high decimal point (mm:ss separator).

## Operation
- **Shadow register (16 bit):**
  - Loaded on an edge where load=1; otherwise it holds.
  - Reset value 0.
- **Prescaler pre:**
  - Width is $clog2(REFRESH_DIV), minimum 1 bit.
  - Counts 0..REFRESH_DIV-1; the terminal count (tc) is pre==REFRESH_DIV-1.
  - On tc, pre wraps to 0 and the digit index idx (2 bit) advances 0→1→2→3→0.
- **Scan wrap:** occurs when tc coincides with idx==3.
- **Decode:**
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
  - Codes 10–15 decode to a dash, 0x40.
- **Leading-zero blanking** (blank_lz=1):
  - Digit 3 is blanked if it is 0.
  - Digit 2 is blanked if digits 3 and 2 are both 0.
  - Digit 1 is blanked if digits 3, 2 and 1 are all 0.
  - Digit 0 is never blanked.
  - A dash (code 10–15) counts as non-zero.
  - A blanked digit gives seg=0, but its an line still goes active.
- **dp:** 1 only while idx==2 and the display is visible.
- **Blink FSM**, two states VIS and DARK, plus a scan counter bcnt:
  - blink_en=0: state forced to VIS, bcnt=0.
  - blink_en=1, on each scan wrap: if bcnt==BLINK_DIV-1, bcnt←0 and the state toggles; else bcnt←bcnt+1.
  - DARK (with blink_en=1): an=4'b1111, seg=0, dp=0.
  - The scan counters keep running in both states.
- **Output stage:** seg, an and dp are registered. Each edge computes them from the current idx, shadow, blank_lz, blink_en and blink state.
- **Reset values:**
  - seg=0, an=4'b1111, dp=0.
  - shadow=0, pre=0, idx=0, bcnt=0, state VIS.

## Timing
- **Load latency:** a load at edge N updates the shadow at N. The new value reaches the outputs at edge N+1, provided that digit is active.
- **Scan timing:**
  - Each digit is active for exactly REFRESH_DIV cycles; a full scan is 4·REFRESH_DIV cycles.
  - The outputs lag idx by one cycle.
  - With REFRESH_DIV=1, idx advances every cycle.
- **Blink half-period:** BLINK_DIV·4·REFRESH_DIV cycles. The first half-period after blink_en rises is VIS.
- **Simultaneous events:**
  - load together with tc: both take effect, so the next digit shows the new shadow value.
  - load during DARK: the shadow updates, with no visible change until VIS.
  - blink_en falling during DARK: the outputs are visible at the next edge.
- **After reset:**
  - First edge after rst_n rises: an=4'b1110 and seg=0x3F.
  - blank_lz only suppresses digits 3–1, so digit 0 shows 0.
- **Reset mid-operation:** asserting rst_n clears all state and outputs immediately, with no clock required.
- **Glitch-free switching:** an and seg switch on the same edge, so no frame ever shows one digit's segments with another digit's enable.

## Test plan
- **Reset:** rst_n=0 mid-scan with digits loaded → seg=0, an=1111, dp=0 immediately. After release → an=1110, seg=0x3F.
- **Scan order:** REFRESH_DIV=4, load 16'h1234 → 4 cycles each of:
  - an=1110, seg=0x66
  - an=1101, seg=0x4F
  - an=1011, seg=0x5B, dp=1
  - an=0111, seg=0x06
  - then repeat.
- **Invalid code with blanking:** load 16'h0A05, blank_lz=1 → digit3 seg=0 (an=0111 still asserted), digit2 0x40, digit1 0x3F, digit0 0x6D.
- **Blanking on/off:** load 16'h0007, blank_lz=1 → digits 3–1 seg=0, digit0 0x07. With blank_lz=0 → 0x3F on digits 3–1.
- **Blink:** REFRESH_DIV=1, BLINK_DIV=2, blink_en=1 → 8 cycles visible, 8 cycles an=1111/seg=0, repeating. Drop blink_en during DARK → visible at the next edge.
- **Load/tc collision:** load 16'h9999 on the tc edge of digit 0 → the next cycle shows an=1101, seg=0x6F.

Source files
------------

// File: rtl/seg_display_dec_if.sv
// seg_display_dec_if
//   Bundle between the timer/encoder side (master) and the display decoder
//   (slave).
//   load     : capture digits into the decoder's shadow register
//   digits   : four BCD nibbles, [15:12] tens of minutes ... [3:0] seconds
//   blank_lz : 1 = suppress leading zeros on digits 3..1
//   blink_en : 1 = blink the whole display
//   seg      : active-high segments {g,f,e,d,c,b,a}
//   an       : one-hot active-low digit enables
//   dp       : active-high mm:ss separator dot
interface seg_display_dec_if;
  logic        load;
  logic [15:0] digits;
  logic        blank_lz;
  logic        blink_en;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;

  modport master (
    output load, digits, blank_lz, blink_en,
    input  seg, an, dp
  );

  modport slave (
    input  load, digits, blank_lz, blink_en,
    output seg, an, dp
  );
endinterface

// File: rtl/seg_display_dec.sv
// seg_display_dec
//   Latches four BCD digits (mm:ss) and scans them onto a multiplexed
//   4-digit 7-segment display with leading-zero blanking, a dash for
//   invalid codes, the separator dot on digit 2 and a whole-display blink.
//   Ports:
//     clk   : system clock, all state on the rising edge
//     rst_n : asynchronous active-low reset
//     bus   : slave side of seg_display_dec_if (load/digits/blank_lz/
//             blink_en in, seg/an/dp out, all outputs registered)
//   Parameters:
//     REFRESH_DIV : cycles each digit stays active (>=1)
//     BLINK_DIV   : full scans per blink half-period (>=1)
module seg_display_dec #(
  parameter int REFRESH_DIV = 4,
  parameter int BLINK_DIV   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  seg_display_dec_if.slave  bus
);

  localparam int PRE_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BCNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLINK_DIV - 1);

  typedef enum logic {VIS, DARK} blink_t;

  logic [15:0]       r_shadow;
  logic [PRE_W-1:0]  r_pre;
  logic [1:0]        r_idx;
  logic [BCNT_W-1:0] r_bcnt;
  blink_t            r_state;
  logic [6:0]        r_seg;
  logic [3:0]        r_an;
  logic              r_dp;

  logic              w_tc;
  logic              w_wrap;
  blink_t            w_state_nxt;
  logic [BCNT_W-1:0] w_bcnt_nxt;
  logic [3:0]        w_digit;
  logic              w_blank;
  logic              w_visible;
  logic [6:0]        w_seg_nxt;
  logic [3:0]        w_an_nxt;
  logic              w_dp_nxt;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40; // dash for non-BCD codes
    endcase
    return s;
  endfunction

  assign w_tc   = (r_pre == PRE_LAST);
  assign w_wrap = w_tc && (r_idx == 2'd3);

  // Shadow register and scan counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_pre    <= '0;
      r_idx    <= '0;
    end else begin
      if (bus.load) r_shadow <= bus.digits;
      if (w_tc) begin
        r_pre <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
    end
  end

  // Blink FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= VIS;
      r_bcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_bcnt  <= w_bcnt_nxt;
    end
  end

  // Blink FSM next state: the scan-wrap counter only runs while blinking,
  // so the first half-period after blink_en rises always starts visible.
  always_comb begin
    w_state_nxt = r_state;
    w_bcnt_nxt  = r_bcnt;
    if (!bus.blink_en) begin
      w_state_nxt = VIS;
      w_bcnt_nxt  = '0;
    end else if (w_wrap) begin
      if (r_bcnt == BCNT_LAST) begin
        w_bcnt_nxt  = '0;
        w_state_nxt = (r_state == VIS) ? DARK : VIS;
      end else begin
        w_bcnt_nxt = r_bcnt + 1'b1;
      end
    end
  end

  // Digit select, blanking and output decode for the digit active now
  always_comb begin
    w_digit = r_shadow[3:0];
    w_blank = 1'b0;
    case (r_idx)
      2'd3: begin
        w_digit = r_shadow[15:12];
        w_blank = (r_shadow[15:12] == 4'd0);
      end
      2'd2: begin
        w_digit = r_shadow[11:8];
        w_blank = (r_shadow[15:8] == 8'd0);
      end
      2'd1: begin
        w_digit = r_shadow[7:4];
        w_blank = (r_shadow[15:4] == 12'd0);
      end
      default: begin
        w_digit = r_shadow[3:0];
        w_blank = 1'b0;
      end
    endcase
    w_blank = w_blank && bus.blank_lz;

    // blink_en is looked at directly so dropping it during DARK shows the
    // display on the very next edge.
    w_visible = !bus.blink_en || (r_state == VIS);

    w_seg_nxt = 7'h00;
    w_an_nxt  = 4'hF;
    w_dp_nxt  = 1'b0;
    if (w_visible) begin
      w_seg_nxt = w_blank ? 7'h00 : bcd_to_seg(w_digit);
      w_an_nxt  = ~(4'b0001 << r_idx);
      w_dp_nxt  = (r_idx == 2'd2);
    end
  end

  // Output registers: seg, an and dp switch on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= 7'h00;
      r_an  <= 4'hF;
      r_dp  <= 1'b0;
    end else begin
      r_seg <= w_seg_nxt;
      r_an  <= w_an_nxt;
      r_dp  <= w_dp_nxt;
    end
  end

  assign bus.seg = r_seg;
  assign bus.an  = r_an;
  assign bus.dp  = r_dp;

endmodule

// File: tb/tb_seg_display_dec.sv
module tb_seg_display_dec;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        t_load = 1'b0;
  logic [15:0] t_digits = 16'h0;
  logic        t_blz = 1'b0;
  logic        t_ben = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seg_display_dec_if bus_a ();
  seg_display_dec_if bus_b ();

  assign bus_a.load = t_load;   assign bus_b.load = t_load;
  assign bus_a.digits = t_digits; assign bus_b.digits = t_digits;
  assign bus_a.blank_lz = t_blz; assign bus_b.blank_lz = t_blz;
  assign bus_a.blink_en = t_ben; assign bus_b.blink_en = t_ben;

  seg_display_dec #(.REFRESH_DIV(4), .BLINK_DIV(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave)
  );
  seg_display_dec #(.REFRESH_DIV(1), .BLINK_DIV(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave)
  );

  // Reference model: cycle count since reset, completed scans while blinking,
  // and the latched digits.
  logic [6:0] segtab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D,
                              7'h07, 7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40,
                              7'h40, 7'h40};
  int          m_cnt   [2];
  int          m_wraps [2];
  logic [15:0] m_sh    [2];

  function automatic int rdiv(input int i); return (i == 0) ? 4 : 1; endfunction
  function automatic int bdiv(input int i); return (i == 0) ? 8 : 2; endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_wraps[i] = 0; m_sh[i] = 16'h0;
    end
  endtask

  task automatic model_out(input int i, output logic [6:0] s,
                           output logic [3:0] a, output logic d);
    int  idx;
    bit  vis, blank;
    logic [3:0] nib;
    idx = (m_cnt[i] / rdiv(i)) % 4;
    vis = !t_ben || (((m_wraps[i] / bdiv(i)) % 2) == 0);
    blank = t_blz && (idx > 0);
    for (int j = idx; j < 4; j++) begin
      nib = m_sh[i][j*4 +: 4];
      if (nib != 4'd0) blank = 1'b0;
    end
    nib = m_sh[i][idx*4 +: 4];
    s = vis ? (blank ? 7'h00 : segtab[nib]) : 7'h00;
    a = vis ? ~(4'b0001 << idx) : 4'hF;
    d = vis && (idx == 2);
  endtask

  task automatic model_step(input int i);
    int scan;
    scan = 4 * rdiv(i);
    if (t_ben) begin
      if ((m_cnt[i] % scan) == scan - 1) m_wraps[i]++;
    end else begin
      m_wraps[i] = 0;
    end
    m_cnt[i]++;
    if (t_load) m_sh[i] = t_digits;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock edge: predict from pre-edge model, advance it, compare both DUTs.
  task automatic tick();
    logic [6:0] es [2];
    logic [3:0] ea [2];
    logic       ed [2];
    for (int i = 0; i < 2; i++) begin
      model_out(i, es[i], ea[i], ed[i]);
      model_step(i);
    end
    @(posedge clk); #1;
    chk("model_a_seg", {1'b0, bus_a.seg}, {1'b0, es[0]});
    chk("model_a_an",  {4'h0, bus_a.an},  {4'h0, ea[0]});
    chk("model_a_dp",  {7'h0, bus_a.dp},  {7'h0, ed[0]});
    chk("model_b_seg", {1'b0, bus_b.seg}, {1'b0, es[1]});
    chk("model_b_an",  {4'h0, bus_b.an},  {4'h0, ea[1]});
    chk("model_b_dp",  {7'h0, bus_b.dp},  {7'h0, ed[1]});
  endtask

  // Asynchronous reset between edges, checked before any clock arrives.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_seg", {1'b0, bus_a.seg}, 8'h00);
    chk("rst_an",  {4'h0, bus_a.an},  8'h0F);
    chk("rst_dp",  {7'h0, bus_a.dp},  8'h00);
    chk("rst_b_an", {4'h0, bus_b.an}, 8'h0F);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [15:0] d;
    logic        blz;
    logic [6:0]  s [4];   // expected seg for digit 0..3
  } vec_t;

  vec_t vt [4];

  initial begin
    vt[0] = '{d: 16'h1234, blz: 1'b0, s: '{7'h66, 7'h4F, 7'h5B, 7'h06}};
    vt[1] = '{d: 16'h0A05, blz: 1'b1, s: '{7'h6D, 7'h3F, 7'h40, 7'h00}};
    vt[2] = '{d: 16'h0007, blz: 1'b1, s: '{7'h07, 7'h00, 7'h00, 7'h00}};
    vt[3] = '{d: 16'h0007, blz: 1'b0, s: '{7'h07, 7'h3F, 7'h3F, 7'h3F}};

    model_reset();
    #12;
    rst_n = 1'b1;
    t_blz = 1'b1;
    tick();
    chk("post_rst_an",  {4'h0, bus_a.an}, 8'h0E);
    chk("post_rst_seg", {1'b0, bus_a.seg}, 8'h3F);

    // Table: load on the first edge after reset, then walk two full scans.
    for (int v = 0; v < 4; v++) begin
      do_reset();
      t_digits = vt[v].d; t_blz = vt[v].blz; t_ben = 1'b0; t_load = 1'b1;
      tick();
      t_load = 1'b0;
      for (int k = 2; k <= 33; k++) begin
        int idx;
        tick();
        idx = ((k - 1) / 4) % 4;
        chk($sformatf("vec%0d_seg_d%0d", v, idx), {1'b0, bus_a.seg}, {1'b0, vt[v].s[idx]});
        chk($sformatf("vec%0d_an_d%0d", v, idx), {4'h0, bus_a.an}, {4'h0, ~(4'b0001 << idx)});
        chk($sformatf("vec%0d_dp_d%0d", v, idx), {7'h0, bus_a.dp}, {7'h0, idx == 2});
      end
    end

    // Reset mid-scan with digits loaded.
    tick(); tick(); tick();
    do_reset();
    t_load = 1'b0; t_blz = 1'b0;
    tick();
    chk("midrst_an",  {4'h0, bus_a.an}, 8'h0E);
    chk("midrst_seg", {1'b0, bus_a.seg}, 8'h3F);

    // Load on the tc edge of digit 0 (edge 4): next frame is digit 1 = 9.
    do_reset();
    t_digits = 16'h1234; t_load = 1'b1;
    tick();
    t_load = 1'b0;
    tick(); tick();
    t_digits = 16'h9999; t_load = 1'b1;
    tick();
    t_load = 1'b0;
    tick();
    chk("collide_an",  {4'h0, bus_a.an}, 8'h0D);
    chk("collide_seg", {1'b0, bus_a.seg}, 8'h6F);

    // Blink on dut_b (REFRESH_DIV=1, BLINK_DIV=2): 8 visible, 8 dark.
    do_reset();
    t_digits = 16'h1234; t_load = 1'b1; t_ben = 1'b1; t_blz = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      bit dark;
      tick();
      t_load = 1'b0;
      dark = (((k - 1) / 8) % 2) == 1;
      chk($sformatf("blink_an_e%0d", k), {4'h0, bus_b.an},
          dark ? 8'h0F : {4'h0, ~(4'b0001 << ((k - 1) % 4))});
      if (dark) chk($sformatf("blink_seg_e%0d", k), {1'b0, bus_b.seg}, 8'h00);
    end

    // Drop blink_en during DARK: visible on the next edge (digit 2 of 1234).
    do_reset();
    t_digits = 16'h1234; t_load = 1'b1; t_ben = 1'b1;
    tick();
    t_load = 1'b0;
    for (int k = 2; k <= 10; k++) tick();
    chk("dark_an", {4'h0, bus_b.an}, 8'h0F);
    t_ben = 1'b0;
    tick();
    chk("unblink_an",  {4'h0, bus_b.an}, 8'h0B);
    chk("unblink_seg", {1'b0, bus_b.seg}, 8'h5B);
    chk("unblink_dp",  {7'h0, bus_b.dp}, 8'h01);

    // Randomized run against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      t_load = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0: t_digits = 16'h0000;
        1: t_digits = {12'h000, 4'($urandom_range(0, 15))};
        2: t_digits = {8'h00, 8'($urandom)};
        default: t_digits = 16'($urandom);
      endcase
      if ($urandom_range(0, 63) == 0) t_blz = ~t_blz;
      if ($urandom_range(0, 199) == 0) t_ben = ~t_ben;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
